// File: rtl/line_prefetch_ctrl.sv
// Display line prefetcher: pulls one RGB565 line per line_sync from DDR2 into a ping-pong line BRAM.
// Define LINE_PREFETCH_STATS_EN to add the underrun_cnt / max_lat statistics ports.
module line_prefetch_ctrl #(
  parameter int          H_PIXELS    = 640,
  parameter int          V_LINES     = 480,
  parameter int          MEM_DW      = 64,
  parameter int          BURST_WORDS = 16,
  parameter logic [27:0] FB_BASE     = 28'h0,
  parameter int          LINE_STRIDE = 1280
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_sync,
  input  logic              frame_sync,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [27:0]       rd_req_addr,
  input  logic              rd_data_valid,
  input  logic [MEM_DW-1:0] rd_data,
  output logic              bram_we,
  output logic [8:0]        bram_addr,
  output logic [MEM_DW-1:0] bram_din,
  output logic              fetch_busy,
  output logic              underrun
`ifdef LINE_PREFETCH_STATS_EN
  ,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       max_lat
`endif
);

  localparam int WORDS       = H_PIXELS * 16 / MEM_DW;
  localparam int BURSTS      = WORDS / BURST_WORDS;
  localparam int BURST_BYTES = BURST_WORDS * MEM_DW / 8;
  localparam int WW          = $clog2(WORDS + 1);
  localparam int WW1         = WW + 1;
  localparam int BW          = $clog2(BURSTS + 1);
  localparam int LW          = $clog2(V_LINES);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     line_q, line_d;
  logic              bank_q, bank_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [WW-1:0]     rcnt_q, rcnt_d;
  logic              pend_q, pend_d;
  logic              under_q, under_d;
  logic              we_q, we_d;
  logic [8:0]        waddr_q, waddr_d;
  logic [MEM_DW-1:0] wdata_q, wdata_d;

  logic [WW1-1:0]    issued;
  logic [WW-1:0]     rcntInc;
  logic [LW-1:0]     nextLine;
  logic              accept, take, lastWord, drainDone;

  // Words still owed by memory = accepted bursts * BURST_WORDS - words received; anything beyond is ignored
  assign issued    = WW1'(burst_q) * WW1'(BURST_WORDS);
  assign take      = rd_data_valid && (issued > WW1'(rcnt_q));
  assign accept    = (state_q == REQ) && rd_req_ready;
  assign rcntInc   = rcnt_q + WW'(take);
  assign nextLine  = (line_q == LW'(V_LINES - 1)) ? '0 : line_q + LW'(1);
  assign lastWord  = (state_q == DATA) && take && (rcnt_q == WW'(WORDS - 1));
  assign drainDone = (issued == WW1'(rcntInc));

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    bank_d  = bank_q;
    burst_d = burst_q + BW'(accept);
    rcnt_d  = rcntInc;
    pend_d  = pend_q;
    under_d = 1'b0;
    we_d    = take && ((state_q == REQ) || (state_q == DATA));
    waddr_d = we_d ? {bank_q, 8'(rcnt_q)} : waddr_q;
    wdata_d = we_d ? rd_data : wdata_q;
    case (state_q)
      IDLE: begin
        if (frame_sync) begin
          state_d = REQ;
          line_d  = '0;
          bank_d  = 1'b0;
          burst_d = '0;
          rcnt_d  = '0;
          pend_d  = 1'b0;
        end else if (line_sync || pend_q) begin
          state_d = REQ;
          line_d  = nextLine;
          bank_d  = ~bank_q;
          burst_d = '0;
          rcnt_d  = '0;
          pend_d  = line_sync && pend_q;
          under_d = line_sync && pend_q;
        end
      end
      default: begin
        // frame_sync outranks everything while busy: abandon the line and flush its in-flight words
        if (frame_sync) begin
          pend_d  = 1'b0;
          state_d = DRAIN;
        end else begin
          if (line_sync) begin
            under_d = 1'b1;
            pend_d  = 1'b1;
          end
          if (accept && (burst_q == BW'(BURSTS - 1))) state_d = DATA;
          if (lastWord) state_d = IDLE;
        end
        if ((state_q == DRAIN) && drainDone) begin
          state_d = REQ;
          line_d  = '0;
          bank_d  = 1'b0;
          burst_d = '0;
          rcnt_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      line_q  <= '0;
      bank_q  <= 1'b0;
      burst_q <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      under_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      bank_q  <= bank_d;
      burst_q <= burst_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      under_q <= under_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rd_req_valid = (state_q == REQ);
  assign rd_req_addr  = FB_BASE + 28'(line_q) * 28'(LINE_STRIDE) + 28'(burst_q) * 28'(BURST_BYTES);
  assign bram_we      = we_q;
  assign bram_addr    = waddr_q;
  assign bram_din     = wdata_q;
  assign fetch_busy   = (state_q != IDLE);
  assign underrun     = under_q;

`ifdef LINE_PREFETCH_STATS_EN
  logic [15:0] ucnt_q, maxlat_q, lat_q, latNext;
  logic        latOn_q, lineStart;

  // Latency is timed only for line_sync-started fetches; a frame_sync abandons the measurement
  assign lineStart = (state_q == IDLE) && !frame_sync && (line_sync || pend_q);
  assign latNext   = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ucnt_q   <= '0;
      maxlat_q <= '0;
      lat_q    <= '0;
      latOn_q  <= 1'b0;
    end else begin
      if (under_d && (ucnt_q != 16'hFFFF)) ucnt_q <= ucnt_q + 16'd1;
      if (lineStart) begin
        lat_q   <= 16'd1;
        latOn_q <= 1'b1;
      end else if (frame_sync) begin
        latOn_q <= 1'b0;
      end else if (latOn_q && lastWord) begin
        latOn_q <= 1'b0;
        if (latNext > maxlat_q) maxlat_q <= latNext;
      end else if (latOn_q) begin
        lat_q <= latNext;
      end
    end
  end

  assign underrun_cnt = ucnt_q;
  assign max_lat      = maxlat_q;
`endif

endmodule
